// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor step per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one difference bit produced per clock, busy high
// DONE  | diff/bout valid, done high for this cycle
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             br_q, bout_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;
   logic             d_bit, br_d, last_step;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf_q;
`endif

   always_comb begin
      d_bit     = a_q[0] ^ b_q[0] ^ br_q;
      br_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      last_step = (cnt_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= SHIFT;
               end else begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               diff_q <= {d_bit, diff_q[WIDTH-1:1]};
               br_q   <= br_d;
               cnt_q  <= cnt_q + CW'(1);
               if (last_step) begin
                  bout_q  <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // borrow into the MSB step vs. borrow out of it
                  ovf_q   <= br_q ^ br_d;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
